// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [1:0]  PCSRC_SEQ  = 2'b00;
    localparam logic [1:0]  PCSRC_BR   = 2'b01;
    localparam logic [1:0]  PCSRC_JALR = 2'b10;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_pc_next_mux.sv
// Next-PC selector: sequential / branch-jal / jalr target, word aligned.
module pc_next_mux
    import fetch_pkg::*;
(
    input  logic [1:0]  pc_src,
    input  logic [31:0] pc_seq,
    input  logic [31:0] pc_plus_imm,
    input  logic [31:0] reg_plus_imm,
    output logic [31:0] pc_next
);

    logic [31:0] sel;
    logic        unused_low;

    always_comb begin
        sel = pc_seq;
        unique case (pc_src)
            PCSRC_BR:   sel = pc_plus_imm;
            PCSRC_JALR: sel = reg_plus_imm;
            default:    sel = pc_seq;
        endcase
    end

    // Low two bits are forced to zero so every target is word aligned.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_align
            if (gi < 2) begin : g_low
                assign pc_next[gi] = 1'b0;
            end else begin : g_high
                assign pc_next[gi] = sel[gi];
            end
        end
    endgenerate

    assign unused_low = ^sel[1:0];

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem handshake FSM, redirect/squash and IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  PCsrc_i,
    input  logic [31:0] pcPlusImm_i,
    input  logic [31:0] regPlusImm_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o,
    output logic        IMemReady_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] miss_cyc_o
`endif
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  tgt_reg, tgt_next;
    logic [31:0]  buf_reg, buf_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  pcif_reg, pcif_next;
    logic [31:0]  pcp4_reg, pcp4_next;
    logic         valid_reg, valid_next;
    logic         load_if;
    logic         redirect;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;

    assign pc_plus4 = pc_reg + 32'd4;
    assign redirect = en_i & valid_reg & ((PCsrc_i == PCSRC_BR) | (PCsrc_i == PCSRC_JALR));

    pc_next_mux u_pc_next_mux (
        .pc_src       (PCsrc_i),
        .pc_seq       (pc_plus4),
        .pc_plus_imm  (pcPlusImm_i),
        .reg_plus_imm (regPlusImm_i),
        .pc_next      (target)
    );

    // Request is masked during reset so memory sees no fetch while rst_i is high.
    assign imem_req_o  = ~rst_i & (state_reg != HOLD);
    assign imem_addr_o = pc_reg;
    assign instr_o     = instr_reg;
    assign pc_o        = pcif_reg;
    assign pcPlus4_o   = pcp4_reg;
    assign IMemReady_o = valid_reg;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        tgt_next   = tgt_reg;
        buf_next   = buf_reg;
        instr_next = instr_reg;
        pcif_next  = pcif_reg;
        pcp4_next  = pcp4_reg;
        valid_next = valid_reg;
        load_if    = 1'b0;
        unique case (state_reg)
            FETCH: begin
                if (redirect) begin
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                    if (imem_ready_i) begin
                        pc_next = target;
                    end else begin
                        // Address must stay put until the wrong-path access completes.
                        tgt_next   = target;
                        state_next = DRAIN;
                    end
                end else if (imem_ready_i) begin
                    if (en_i) begin
                        load_if    = 1'b1;
                        instr_next = imem_rdata_i;
                        pcif_next  = pc_reg;
                        pcp4_next  = pc_plus4;
                        valid_next = 1'b1;
                        pc_next    = pc_plus4;
                    end else begin
                        buf_next   = imem_rdata_i;
                        state_next = HOLD;
                    end
                end else if (en_i) begin
                    valid_next = 1'b0;
                    instr_next = NOP_INSTR;
                end
            end
            DRAIN: begin
                if (imem_ready_i) begin
                    pc_next    = tgt_reg;
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (en_i) begin
                    state_next = FETCH;
                    if (redirect) begin
                        pc_next    = target;
                        valid_next = 1'b0;
                        instr_next = NOP_INSTR;
                    end else begin
                        load_if    = 1'b1;
                        instr_next = buf_reg;
                        pcif_next  = pc_reg;
                        pcp4_next  = pc_plus4;
                        valid_next = 1'b1;
                        pc_next    = pc_plus4;
                    end
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            tgt_reg   <= 32'd0;
            buf_reg   <= 32'd0;
            instr_reg <= NOP_INSTR;
            pcif_reg  <= 32'd0;
            pcp4_reg  <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            tgt_reg   <= tgt_next;
            buf_reg   <= buf_next;
            instr_reg <= instr_next;
            pcif_reg  <= pcif_next;
            pcp4_reg  <= pcp4_next;
            valid_reg <= valid_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] miss_cyc_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_reg <= 32'd0;
            miss_cyc_reg  <= 32'd0;
        end else begin
            if (load_if) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (imem_req_o & ~imem_ready_i) begin
                miss_cyc_reg <= miss_cyc_reg + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;
    assign miss_cyc_o  = miss_cyc_reg;
`else
    // Without counters the IF/ID load strobe has no consumer.
    logic unused_load_if;
    assign unused_load_if = load_if;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus an IF/ID scoreboard.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] DBEEF  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] ppi = 32'd0;
    logic [31:0] rpi = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        ivalid;
    logic        drive_dbeef = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] miss_cyc;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .PCsrc_i      (pcsrc),
        .pcPlusImm_i  (ppi),
        .regPlusImm_i (rpi),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .imem_ready_i (imem_ready),
        .instr_o      (instr),
        .pc_o         (pc),
        .pcPlus4_o    (pcp4),
        .IMemReady_o  (ivalid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o  (fetch_cnt),
        .miss_cyc_o   (miss_cyc)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always_comb imem_rdata = drive_dbeef ? DBEEF : mem_word(imem_addr);

    typedef struct {
        logic        en;
        logic        rdy;
        logic [1:0]  src;
        logic [31:0] ppi;
        logic [31:0] rpi;
        logic        dbeef;
        logic [31:0] addr;
        logic        req;
        logic        push;
        logic        push_dbeef;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_t;

    vec_t  vecs[29];
    ifid_t sb_q[$];
    ifid_t cur_exp;

    function automatic vec_t V(input logic e, input logic r, input logic [1:0] s,
                               input logic [31:0] p, input logic [31:0] q, input logic d,
                               input logic [31:0] a, input logic rq, input logic pu,
                               input logic pd, input logic v);
        vec_t t;
        t.en = e; t.rdy = r; t.src = s; t.ppi = p; t.rpi = q; t.dbeef = d;
        t.addr = a; t.req = rq; t.push = pu; t.push_dbeef = pd; t.valid = v;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = V(1, 1, 2'd0, 0, 0, 0, 32'h1000, 1, 1, 0, 1);
        vecs[1]  = V(1, 1, 2'd0, 0, 0, 0, 32'h1004, 1, 1, 0, 1);
        vecs[2]  = V(1, 1, 2'd0, 0, 0, 0, 32'h1008, 1, 1, 0, 1);
        vecs[3]  = V(1, 0, 2'd0, 0, 0, 0, 32'h100C, 1, 0, 0, 0);
        vecs[4]  = V(1, 0, 2'd0, 0, 0, 0, 32'h100C, 1, 0, 0, 0);
        vecs[5]  = V(1, 1, 2'd0, 0, 0, 0, 32'h100C, 1, 1, 0, 1);
        vecs[6]  = V(1, 1, 2'd1, 32'h100, 0, 0, 32'h1010, 1, 0, 0, 0);
        vecs[7]  = V(1, 1, 2'd0, 0, 0, 0, 32'h0100, 1, 1, 0, 1);
        vecs[8]  = V(1, 1, 2'd0, 0, 0, 0, 32'h0104, 1, 1, 0, 1);
        vecs[9]  = V(1, 0, 2'd2, 0, 32'h206, 0, 32'h0108, 1, 0, 0, 0);
        vecs[10] = V(1, 0, 2'd2, 0, 32'h206, 0, 32'h0108, 1, 0, 0, 0);
        vecs[11] = V(1, 0, 2'd0, 0, 0, 0, 32'h0108, 1, 0, 0, 0);
        vecs[12] = V(1, 1, 2'd0, 0, 0, 0, 32'h0108, 1, 0, 0, 0);
        vecs[13] = V(1, 1, 2'd0, 0, 0, 0, 32'h0204, 1, 1, 0, 1);
        vecs[14] = V(0, 1, 2'd0, 0, 0, 1, 32'h0208, 1, 0, 0, 1);
        vecs[15] = V(0, 0, 2'd0, 0, 0, 0, 32'h0208, 0, 0, 0, 1);
        vecs[16] = V(0, 1, 2'd0, 0, 0, 0, 32'h0208, 0, 0, 0, 1);
        vecs[17] = V(1, 0, 2'd0, 0, 0, 0, 32'h0208, 0, 1, 1, 1);
        vecs[18] = V(1, 1, 2'd0, 0, 0, 0, 32'h020C, 1, 1, 0, 1);
        vecs[19] = V(0, 1, 2'd0, 0, 0, 0, 32'h0210, 1, 0, 0, 1);
        vecs[20] = V(1, 0, 2'd1, 32'h303, 0, 0, 32'h0210, 0, 0, 0, 0);
        vecs[21] = V(1, 1, 2'd0, 0, 0, 0, 32'h0300, 1, 1, 0, 1);
        vecs[22] = V(1, 1, 2'd1, 32'hFFFF_FFFC, 0, 0, 32'h0304, 1, 0, 0, 0);
        vecs[23] = V(1, 1, 2'd0, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 0, 1);
        vecs[24] = V(1, 1, 2'd0, 0, 0, 0, 32'h0000_0000, 1, 1, 0, 1);
        vecs[25] = V(1, 1, 2'd3, 32'h500, 0, 0, 32'h0000_0004, 1, 1, 0, 1);
        vecs[26] = V(0, 0, 2'd0, 0, 0, 0, 32'h0000_0008, 1, 0, 0, 1);
        vecs[27] = V(0, 0, 2'd1, 32'h700, 0, 0, 32'h0000_0008, 1, 0, 0, 1);
        vecs[28] = V(1, 1, 2'd0, 0, 0, 0, 32'h0000_0008, 1, 1, 0, 1);
        cur_exp.instr = NOP;
        cur_exp.pc    = 32'd0;

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ivalid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pcp4", pcp4, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, RST_PC);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            en = vecs[i].en; imem_ready = vecs[i].rdy; pcsrc = vecs[i].src;
            ppi = vecs[i].ppi; rpi = vecs[i].rpi; drive_dbeef = vecs[i].dbeef;
            #1;
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
            if (vecs[i].push) begin
                ifid_t e;
                e.instr = vecs[i].push_dbeef ? DBEEF : mem_word(vecs[i].addr);
                e.pc    = vecs[i].addr;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) cur_exp = sb_q.pop_front();
            chk($sformatf("v%0d_valid", i), {31'd0, ivalid}, {31'd0, vecs[i].valid});
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_instr", i), instr, cur_exp.instr);
                chk($sformatf("v%0d_pc", i), pc, cur_exp.pc);
                chk($sformatf("v%0d_pcp4", i), pcp4, cur_exp.pc + 32'd4);
            end else begin
                chk($sformatf("v%0d_nop", i), instr, NOP);
            end
            $display("vec %0d: addr=%h req=%b valid=%b instr=%h pc=%h",
                     i, vecs[i].addr, vecs[i].req, ivalid, instr, pc);
        end

        // Reset asserted between clock edges while waiting in DRAIN
        @(negedge clk);
        en = 1'b1; imem_ready = 1'b0; pcsrc = 2'd2; rpi = 32'h404; drive_dbeef = 1'b0;
        @(negedge clk);
        pcsrc = 2'd0;
        #1;
        chk("drain_addr", imem_addr, 32'h0000_000C);
        chk("drain_valid", {31'd0, ivalid}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_addr", imem_addr, RST_PC);
        chk("async_instr", instr, NOP);
        chk("async_pc", pc, 32'd0);
        $display("async reset: addr=%h req=%b valid=%b", imem_addr, imem_req, ivalid);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("post_rst_addr", imem_addr, RST_PC);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, ivalid}, 32'd1);
        chk("post_rst_instr", instr, mem_word(RST_PC));
        chk("post_rst_pc", pc, RST_PC);
        $display("post reset fetch: pc=%h instr=%h", pc, instr);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
